// File: rtl/skew_stream_feeder.sv
// Diagonal-skew feeder: stores a ROWS x COLS operand matrix and streams it as
// ROWS+COLS-1 wavefront beats. Define SKEW_STREAM_FEEDER_PINGPONG_EN for a shadow buffer.
module skew_stream_feeder #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned ROWS  = 3,
    parameter int unsigned COLS  = 3,
    localparam int unsigned BEATS = ROWS + COLS - 1,
    localparam int unsigned BW    = (BEATS > 1) ? $clog2(BEATS) : 1
) (
    input  logic                                   clock,
    input  logic                                   nreset,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  logic [ROWS-1:0][COLS-1:0][WIDTH-1:0]   Min,
    input  logic                                   in_reverse,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic [ROWS*WIDTH-1:0]                  out_data,
    output logic [ROWS-1:0]                        out_lane_mask,
    output logic [BW-1:0]                          out_beat,
    output logic                                   out_last,
    output logic                                   busy,
    output logic                                   done
);

    localparam int unsigned   CW        = (COLS > 1) ? $clog2(COLS) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

    typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

    state_t                                state;
    logic [BW-1:0]                         beat;
    logic [ROWS-1:0][COLS-1:0][WIDTH-1:0]  mat;
    logic                                  rev;

    logic                                  accept;
    logic                                  take;
    logic                                  last_take;
    logic                                  shadow_hit;
    logic                                  load_beat;
    logic                                  clear_beat;
    logic [ROWS-1:0][COLS-1:0][WIDTH-1:0]  emit_mat;
    logic                                  emit_rev;
    logic [BW-1:0]                         emit_beat;

`ifdef SKEW_STREAM_FEEDER_PINGPONG_EN
    logic [ROWS-1:0][COLS-1:0][WIDTH-1:0]  shadow;
    logic                                  shadow_rev;
    logic                                  shadow_full;
    logic                                  shadow_load;
    logic                                  shadow_full_n;
`endif

    // Lane r carries element t-d(r) when that index lies inside the row.
    function automatic logic [ROWS-1:0] lane_mask(input logic r, input logic [BW-1:0] t);
        logic [ROWS-1:0] m;
        int              k;
        m = '0;
        for (int i = 0; i < int'(ROWS); i++) begin
            k    = int'(t) - (r ? (int'(ROWS) - 1 - i) : i);
            m[i] = (k >= 0) && (k < int'(COLS));
        end
        return m;
    endfunction

    function automatic logic [ROWS*WIDTH-1:0] lane_data(
        input logic [ROWS-1:0][COLS-1:0][WIDTH-1:0] m,
        input logic                                 r,
        input logic [BW-1:0]                        t
    );
        logic [ROWS*WIDTH-1:0] d;
        logic [ROWS-1:0]       v;
        int                    k;
        d = '0;
        v = lane_mask(r, t);
        for (int i = 0; i < int'(ROWS); i++) begin
            k = int'(t) - (r ? (int'(ROWS) - 1 - i) : i);
            if (v[i]) d[i*WIDTH +: WIDTH] = m[i][CW'(k)];
        end
        return d;
    endfunction

    assign accept    = in_valid && in_ready;
    assign take      = (state == STREAM) && out_valid && out_ready;
    assign last_take = take && (beat == LAST_BEAT);

`ifdef SKEW_STREAM_FEEDER_PINGPONG_EN
    assign shadow_hit    = shadow_full;
    assign shadow_load   = accept && (state == STREAM);
    assign shadow_full_n = shadow_load || (shadow_full && !last_take);
`else
    assign shadow_hit    = 1'b0;
`endif

    // Source of the next beat: a fresh accept, the shadow on a drain, or the current matrix.
    always_comb begin
        emit_mat  = mat;
        emit_rev  = rev;
        emit_beat = beat + BW'(1);
        if (state != STREAM) begin
            emit_mat  = Min;
            emit_rev  = in_reverse;
            emit_beat = '0;
        end
`ifdef SKEW_STREAM_FEEDER_PINGPONG_EN
        else if (beat == LAST_BEAT) begin
            emit_mat  = shadow;
            emit_rev  = shadow_rev;
            emit_beat = '0;
        end
`endif
    end

    always_comb begin
        load_beat  = 1'b0;
        clear_beat = 1'b0;
        if (state != STREAM) begin
            load_beat = accept;
        end else if (take) begin
            load_beat  = (beat != LAST_BEAT) || shadow_hit;
            clear_beat = (beat == LAST_BEAT) && !shadow_hit;
        end
    end

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            state         <= IDLE;
            beat          <= '0;
            mat           <= '0;
            rev           <= 1'b0;
            in_ready      <= 1'b0;
            out_valid     <= 1'b0;
            out_data      <= '0;
            out_lane_mask <= '0;
            out_beat      <= '0;
            out_last      <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
`ifdef SKEW_STREAM_FEEDER_PINGPONG_EN
            shadow        <= '0;
            shadow_rev    <= 1'b0;
            shadow_full   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE:    if (accept) state <= STREAM;
                STREAM:  if (clear_beat) state <= DONE;
                DONE:    state <= accept ? STREAM : IDLE;
                default: state <= IDLE;
            endcase

            if (load_beat) begin
                mat           <= emit_mat;
                rev           <= emit_rev;
                beat          <= emit_beat;
                out_valid     <= 1'b1;
                out_data      <= lane_data(emit_mat, emit_rev, emit_beat);
                out_lane_mask <= lane_mask(emit_rev, emit_beat);
                out_beat      <= emit_beat;
                out_last      <= (emit_beat == LAST_BEAT);
                busy          <= 1'b1;
            end else if (clear_beat) begin
                out_valid     <= 1'b0;
                out_data      <= '0;
                out_lane_mask <= '0;
                out_beat      <= '0;
                out_last      <= 1'b0;
                busy          <= 1'b0;
            end

            done <= last_take;

`ifdef SKEW_STREAM_FEEDER_PINGPONG_EN
            if (shadow_load) begin
                shadow     <= Min;
                shadow_rev <= in_reverse;
            end
            shadow_full <= shadow_full_n;
            in_ready    <= !shadow_full_n;
`else
            in_ready    <= (state == DONE) || ((state == IDLE) && !accept);
`endif
        end
    end

endmodule

// File: tb/tb_skew_stream_feeder.sv
// Directed self-checking bench for skew_stream_feeder (3x3, 4-bit elements).
module tb_skew_stream_feeder;

    typedef logic [2:0][2:0][3:0] mat_t;

`ifdef SKEW_STREAM_FEEDER_PINGPONG_EN
    localparam bit PP = 1'b1;
`else
    localparam bit PP = 1'b0;
`endif

    logic        clock  = 1'b0;
    logic        nreset = 1'b1;
    logic        in_valid;
    logic        in_ready;
    mat_t        Min;
    logic        in_reverse;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] out_data;
    logic [2:0]  out_lane_mask;
    logic [2:0]  out_beat;
    logic        out_last;
    logic        busy;
    logic        done;

    int checks   = 0;
    int failures = 0;

    mat_t mat_a;
    mat_t mat_f;
    int   a_tab [3][3] = '{'{1, 2, 3}, '{7, 6, 5}, '{8, 9, 4}};

    logic [11:0] fwd_d [5] = '{12'h001, 12'h072, 12'h863, 12'h950, 12'h400};
    logic [2:0]  fwd_m [5] = '{3'b001, 3'b011, 3'b111, 3'b110, 3'b100};
    logic [11:0] rev_d [5] = '{12'h800, 12'h970, 12'h461, 12'h052, 12'h003};
    logic [2:0]  rev_m [5] = '{3'b100, 3'b110, 3'b111, 3'b011, 3'b001};
    logic [11:0] ff_d  [5] = '{12'hF00, 12'hFF0, 12'hFFF, 12'h0FF, 12'h00F};

    skew_stream_feeder #(.WIDTH(4), .ROWS(3), .COLS(3)) dut (
        .clock(clock), .nreset(nreset),
        .in_valid(in_valid), .in_ready(in_ready), .Min(Min), .in_reverse(in_reverse),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_lane_mask(out_lane_mask), .out_beat(out_beat), .out_last(out_last),
        .busy(busy), .done(done)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_beat(input string tag, input logic [11:0] d, input logic [2:0] m, input int t);
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_data"}, 32'(out_data), 32'(d));
        check({tag, "_mask"}, 32'(out_lane_mask), 32'(m));
        check({tag, "_beat"}, 32'(out_beat), 32'(t));
        check({tag, "_last"}, 32'(out_last), (t == 4) ? 32'd1 : 32'd0);
    endtask

    task automatic accept(input mat_t m, input logic r);
        int n = 0;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        check("accept_ready", 32'(in_ready), 32'd1);
        Min        = m;
        in_reverse = r;
        in_valid   = 1'b1;
        tick();
        in_valid   = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 40) begin
            tick();
            n++;
        end
        check("done_seen", 32'(done), 32'd1);
    endtask

    initial begin
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++) begin
                mat_a[r][c] = 4'(a_tab[r][c]);
                mat_f[r][c] = 4'hF;
            end
        in_valid   = 1'b0;
        in_reverse = 1'b0;
        out_ready  = 1'b1;
        Min        = '0;

        // Reset state
        #1 nreset = 1'b0;
        #11;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        nreset = 1'b1;
        tick();
        check("idle_in_ready", 32'(in_ready), 32'd1);

        // Forward skew
        accept(mat_a, 1'b0);
        for (int t = 0; t < 5; t++) begin
            check_beat("fwd", fwd_d[t], fwd_m[t], t);
            tick();
        end
        check("fwd_done", 32'(done), 32'd1);
        check("fwd_done_valid", 32'(out_valid), 32'd0);
        check("fwd_done_busy", 32'(busy), 32'd0);
        check("fwd_done_ready", 32'(in_ready), 32'(PP));
        tick();
        check("fwd_done_pulse", 32'(done), 32'd0);
        check("fwd_idle_ready", 32'(in_ready), 32'd1);

        // Reverse skew
        accept(mat_a, 1'b1);
        for (int t = 0; t < 5; t++) begin
            check_beat("rev", rev_d[t], rev_m[t], t);
            tick();
        end
        check("rev_done", 32'(done), 32'd1);
        tick();

        // Backpressure at beat 2 for three cycles
        accept(mat_a, 1'b0);
        check_beat("bp", fwd_d[0], fwd_m[0], 0);
        tick();
        check_beat("bp", fwd_d[1], fwd_m[1], 1);
        tick();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check_beat("bp_hold", fwd_d[2], fwd_m[2], 2);
            check("bp_hold_done", 32'(done), 32'd0);
            tick();
        end
        out_ready = 1'b1;
        for (int t = 2; t < 5; t++) begin
            check_beat("bp", fwd_d[t], fwd_m[t], t);
            tick();
        end
        check("bp_done", 32'(done), 32'd1);
        tick();

`ifdef SKEW_STREAM_FEEDER_PINGPONG_EN
        // Second matrix into the shadow at beat 1, streamed with no bubble
        accept(mat_a, 1'b0);
        check("pp_ready_stream", 32'(in_ready), 32'd1);
        check_beat("pp_a", fwd_d[0], fwd_m[0], 0);
        tick();
        check_beat("pp_a", fwd_d[1], fwd_m[1], 1);
        Min        = mat_f;
        in_reverse = 1'b1;
        in_valid   = 1'b1;
        tick();
        in_valid   = 1'b0;
        check("pp_shadow_full", 32'(in_ready), 32'd0);
        for (int t = 2; t < 5; t++) begin
            check_beat("pp_a", fwd_d[t], fwd_m[t], t);
            tick();
        end
        check_beat("pp_f", ff_d[0], rev_m[0], 0);
        check("pp_done_overlap", 32'(done), 32'd1);
        check("pp_busy", 32'(busy), 32'd1);
        check("pp_ready_drained", 32'(in_ready), 32'd1);
        tick();
        check("pp_done_pulse", 32'(done), 32'd0);
        for (int t = 1; t < 5; t++) begin
            check_beat("pp_f", ff_d[t], rev_m[t], t);
            tick();
        end
        check("pp_done", 32'(done), 32'd1);
        tick();
`else
        // in_valid during STREAM/DONE is held off until IDLE
        accept(mat_a, 1'b0);
        tick();
        Min        = mat_f;
        in_reverse = 1'b0;
        in_valid   = 1'b1;
        check("blk_ready", 32'(in_ready), 32'd0);
        for (int t = 1; t < 5; t++) begin
            check_beat("blk", fwd_d[t], fwd_m[t], t);
            tick();
        end
        check("blk_done", 32'(done), 32'd1);
        check("blk_done_ready", 32'(in_ready), 32'd0);
        tick();
        check("blk_idle_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        check_beat("blk_new", 12'h00F, 3'b001, 0);
        wait_done();
        tick();
`endif

        // Async reset at beat 3: everything drops at once, no done
        accept(mat_a, 1'b0);
        tick();
        tick();
        tick();
        check_beat("ar", fwd_d[3], fwd_m[3], 3);
        #2 nreset = 1'b0;
        #1;
        check("ar_valid", 32'(out_valid), 32'd0);
        check("ar_data", 32'(out_data), 32'd0);
        check("ar_mask", 32'(out_lane_mask), 32'd0);
        check("ar_busy", 32'(busy), 32'd0);
        check("ar_ready", 32'(in_ready), 32'd0);
        tick();
        check("ar_no_done", 32'(done), 32'd0);
        nreset = 1'b1;
        tick();
        check("ar_idle_ready", 32'(in_ready), 32'd1);
        accept(mat_a, 1'b1);
        for (int t = 0; t < 5; t++) begin
            check_beat("ar_rev", rev_d[t], rev_m[t], t);
            tick();
        end
        check("ar_done", 32'(done), 32'd1);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
